// File: rtl/mem_pkg.sv
// Shared types and widths for the load/store issue unit.
package mem_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 3;
    localparam int ROB_W  = 2;

    // One queued memory request as accepted from dispatch.
    typedef struct packed {
        logic              is_load;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [ROB_W-1:0]  rob_idx;
    } mem_req_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } issue_state_t;

endpackage

// File: rtl/mem_issue_unit_if.sv
// Bundle of dispatch, memory-unit and completion signals of the issue unit.
// master = the issue unit itself, slave = dispatch/memory/ROB side.
interface mem_issue_unit_if
    import mem_pkg::*;
#(
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              req_valid;
    logic              req_ready;
    logic              req_is_load;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [ROB_W-1:0]  req_rob_idx;
    logic              flush;

    logic              mem_start_read;
    logic              mem_start_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic [ROB_W-1:0]  mem_rob_idx;
    logic              mem_busy;
    logic              mem_done;
    logic [DATA_W-1:0] mem_read_data;
    logic [ROB_W-1:0]  mem_rob_idx_ret;

    logic              cpl_valid;
    logic              cpl_is_load;
    logic [DATA_W-1:0] cpl_data;
    logic [ROB_W-1:0]  cpl_rob_idx;
    logic [CNT_W-1:0]  queue_count;
    logic              tag_err;

    modport master (
        input  req_valid, req_is_load, req_addr, req_data, req_rob_idx, flush,
        input  mem_busy, mem_done, mem_read_data, mem_rob_idx_ret,
        output req_ready, mem_start_read, mem_start_write, mem_addr,
        output mem_write_data, mem_rob_idx,
        output cpl_valid, cpl_is_load, cpl_data, cpl_rob_idx, queue_count, tag_err
    );

    modport slave (
        output req_valid, req_is_load, req_addr, req_data, req_rob_idx, flush,
        output mem_busy, mem_done, mem_read_data, mem_rob_idx_ret,
        input  req_ready, mem_start_read, mem_start_write, mem_addr,
        input  mem_write_data, mem_rob_idx,
        input  cpl_valid, cpl_is_load, cpl_data, cpl_rob_idx, queue_count, tag_err
    );

endinterface

// File: rtl/mem_req_fifo.sv
// In-order request queue. Head is read combinationally so the issuer can
// present it on the memory port in the same cycle it pops it.
module mem_req_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  mem_req_t         push_data,
    output mem_req_t         head,
    output logic [CNT_W-1:0] count
);

    mem_req_t         entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full queue never accepts, even if the head leaves this cycle.
    assign do_push = push && (count < CNT_W'(DEPTH)) && !flush;
    assign do_pop  = pop && (count != '0) && !flush;
    assign head    = entries[rd_ptr];

    // Entry storage; payload needs no reset since count gates its use.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); flush empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/mem_issue_unit.sv
// Load/store issue unit: queues dispatch requests, issues them one at a time
// to the memory unit and returns a registered completion to the ROB.
// Optional: define MEM_ROB_CHECK_EN to compare the returned ROB tag against
// the in-flight tag and raise a sticky tag_err on mismatch.
module mem_issue_unit
    import mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_issue_unit_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    issue_state_t     state;
    mem_req_t         head;
    mem_req_t         push_req;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             issue;
    logic             done_wait;
    logic             inflight_is_load;
    logic [ROB_W-1:0] inflight_rob;
    logic             drop;
    logic             tag_err;

    assign bus.req_ready = (count < CNT_W'(DEPTH)) && !bus.flush;
    assign push          = bus.req_valid && bus.req_ready;
    assign push_req      = '{is_load: bus.req_is_load, addr: bus.req_addr,
                             data: bus.req_data, rob_idx: bus.req_rob_idx};

    // A flush in S_REQ cancels the issue: no start and no pop.
    assign issue     = (state == S_REQ) && !bus.flush;
    assign done_wait = (state == S_WAIT) && bus.mem_done;

    mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (issue),
        .flush     (bus.flush),
        .push_data (push_req),
        .head      (head),
        .count     (count)
    );

    assign bus.queue_count     = count;
    assign bus.mem_start_read  = issue && head.is_load;
    assign bus.mem_start_write = issue && !head.is_load;
    assign bus.mem_addr        = (state == S_REQ) ? head.addr    : '0;
    assign bus.mem_write_data  = (state == S_REQ) ? head.data    : '0;
    assign bus.mem_rob_idx     = (state == S_REQ) ? head.rob_idx : '0;

    // Issue sequencer; waits out mem_busy after reset before the first issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            inflight_is_load <= 1'b0;
            inflight_rob     <= '0;
            drop             <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count != '0 && !bus.mem_busy && !bus.flush) state <= S_REQ;
                end
                S_REQ: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        inflight_is_load <= head.is_load;
                        inflight_rob     <= head.rob_idx;
                        state            <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_done) begin
                        drop  <= 1'b0;
                        state <= (count != '0 && !bus.flush) ? S_REQ : S_IDLE;
                    end else if (bus.flush) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Registered completion; a flush landing on the done cycle also discards it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cpl_valid   <= 1'b0;
            bus.cpl_is_load <= 1'b0;
            bus.cpl_data    <= '0;
            bus.cpl_rob_idx <= '0;
        end else begin
            bus.cpl_valid <= done_wait && !drop && !bus.flush;
            if (done_wait && !drop && !bus.flush) begin
                bus.cpl_is_load <= inflight_is_load;
                bus.cpl_data    <= inflight_is_load ? bus.mem_read_data : '0;
                bus.cpl_rob_idx <= inflight_rob;
            end
        end
    end

`ifdef MEM_ROB_CHECK_EN
    // Sticky flag for a returned tag that differs from the in-flight one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_err <= 1'b0;
        end else if (done_wait && (bus.mem_rob_idx_ret != inflight_rob)) begin
            tag_err <= 1'b1;
        end
    end
`else
    logic unused_rob_ret;
    assign unused_rob_ret = ^bus.mem_rob_idx_ret;
    assign tag_err        = 1'b0;
`endif

    assign bus.tag_err = tag_err;

endmodule

// File: doc/mem_issue_unit.md
Name: mem_issue_unit

Overview:
- Initiator side of the load/store memory port.
- Accepts load/store requests from dispatch into a small in-order queue.
- Issues one request at a time to the memory unit with single-cycle start pulses, waits for its done pulse, then returns a registered completion to the ROB/writeback path.
- Only one memory operation is outstanding at any time.

Parameters:
DEPTH, 2, request queue entries (power of two, >=2)
ADDR_W, 2, memory address width
DATA_W, 3, data width
ROB_W, 2, ROB index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  dispatch offers a request
req_ready  out  1  queue can accept this cycle
req_is_load  in  1  1 = load, 0 = store
req_addr  in  ADDR_W  target address
req_data  in  DATA_W  store data (ignored for loads)
req_rob_idx  in  ROB_W  ROB tag
flush  in  1  discard pending and in-flight work
mem_start_read  out  1  one-cycle read start to memory unit
mem_start_write  out  1  one-cycle write start to memory unit
mem_addr  out  ADDR_W  issued address
mem_write_data  out  DATA_W  issued store data
mem_rob_idx  out  ROB_W  issued ROB tag
mem_busy  in  1  memory unit busy
mem_done  in  1  memory unit completion pulse
mem_read_data  in  DATA_W  load data, valid with mem_done
mem_rob_idx_ret  in  ROB_W  returned tag, valid with mem_done
cpl_valid  out  1  completion pulse to ROB
cpl_is_load  out  1  completed op was a load
cpl_data  out  DATA_W  load data (0 for stores)
cpl_rob_idx  out  ROB_W  completed tag
queue_count  out  $clog2(DEPTH)+1  occupied entries
tag_err  out  1  sticky tag-mismatch flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - Queue empty; FSM in S_IDLE; drop flag cleared.
  - All outputs 0 except req_ready=1.
- Queue:
  - Push when req_valid && req_ready.
  - req_ready = (queue_count < DEPTH) && !flush. At full, no push even if a pop occurs in the same cycle.
  - Pop happens in S_REQ. Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH. Ordering is strictly FIFO.
- FSM S_IDLE / S_REQ / S_WAIT:
  - S_IDLE: if queue_count>0 && !mem_busy && !flush -> S_REQ. A mem_done seen in S_IDLE is ignored.
  - S_REQ: combinationally drive the head entry on mem_addr / mem_write_data / mem_rob_idx.
    - Assert mem_start_read (load) or mem_start_write (store) for exactly this one cycle, never both.
    - Pop the head, latch is_load and rob_idx into in-flight registers, go to S_WAIT.
    - If flush is high in S_REQ: suppress start, do not pop, go to S_IDLE.
  - S_WAIT: start outputs held at 0; wait for mem_done.
    - On mem_done: if queue_count>0 (post-pop) && !flush, go to S_REQ; else go to S_IDLE.
    - mem_busy is not used to leave S_WAIT. The memory unit deasserts busy in the same cycle done pulses.
- Completion:
  - Registered: cpl_valid is high exactly one cycle, the cycle after mem_done in S_WAIT, unless the drop flag is set.
  - cpl_data = mem_read_data for loads, 0 for stores. cpl_rob_idx = in-flight tag.
- Latency: request accepted at edge T -> start asserted in cycle T+2 (queue empty, memory idle) -> cpl_valid at mem_done+1.
- Flush:
  - Clears queue and count at the next edge.
  - If in S_WAIT, sets the drop flag. That in-flight completion is suppressed, the FSM still waits for mem_done, and the drop flag clears on that mem_done.
- Reset mid-operation:
  - The issuer returns to S_IDLE immediately and stays there until mem_busy is low before issuing again.

Optional Feature:
- Macro: MEM_ROB_CHECK_EN.
- Defined: on mem_done in S_WAIT, compare mem_rob_idx_ret with the in-flight tag. On mismatch, set tag_err; it stays set until rst. The completion still uses the in-flight tag.
- Undefined: no comparator; tag_err tied to 0; mem_rob_idx_ret unused.

Decomposition:
- Package mem_pkg: ADDR_W/DATA_W/ROB_W constants; mem_req_t struct {is_load, addr, data, rob_idx}; issue_state_t enum {S_IDLE, S_REQ, S_WAIT}.
- Sub-module mem_req_fifo: DEPTH-entry FIFO of mem_req_t with push/pop/flush/count. The FSM and completion logic live in the top module.

Test Plan:
- Memory model: busy C1..C4, done 5 cycles after the start edge; mem initialised to mem[i]=i.
- Single load addr=2, rob=1 -> mem_start_read one cycle at T+2; cpl_valid=1, cpl_is_load=1, cpl_data=2, cpl_rob_idx=1, one cycle after mem_done.
- Store addr=3 data=5 rob=2, then load addr=3 rob=3 -> two starts, never overlapping. Completions in order: {store, data 0, rob 2}, then {load, data 5, rob 3}.
- Push 3 requests back-to-back with DEPTH=2 -> req_ready=0 once count=2. Third request is accepted after the first pop; all three complete in order; pointer wrap is exercised.
- Flush during S_WAIT with one request queued -> queue_count=0 next cycle; no cpl_valid for the in-flight op; FSM returns to S_IDLE after mem_done; no further starts.
- rst pulse during S_WAIT while the model stays busy -> outputs 0; no start until mem_busy falls; stray mem_done gives no cpl_valid.
- With MEM_ROB_CHECK_EN, model returns rob=0 for issued rob=2 -> tag_err=1 and stays set; without the macro, tag_err stays 0.
